// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester and FIFO write-port signals of the shared FIFO write arbiter
interface fifo_wr_arbiter_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_almostfull;
    logic                          fifo_overflow;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic [15:0]                   wr_count;
    logic                          err_overflow;

    modport master (
        output req, req_data, fifo_full, fifo_almostfull, fifo_overflow,
        input  gnt, fifo_wr_en, fifo_data_in, wr_count, err_overflow
    );

    modport slave (
        input  req, req_data, fifo_full, fifo_almostfull, fifo_overflow,
        output gnt, fifo_wr_en, fifo_data_in, wr_count, err_overflow
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port; FIFO_ARB_BURST_EN enables burst grants
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || FIFO_DEPTH < 2 || BURST_LEN < 1) begin : g_bad_param
        $error("fifo_wr_arbiter: unsupported parameter set");
    end

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;
    logic          allow;
    logic          xfer;
    int            idx;
`ifdef FIFO_ARB_BURST_EN
    localparam int BW = $clog2(BURST_LEN + 1);
    logic [BW-1:0] burst_cnt;
    logic          burst_go;
`endif

    // Winner selection: rotate from ptr+1, throttled by FIFO room; a write already in flight counts
    always_comb begin
        allow = !bus.fifo_full && !(bus.fifo_wr_en && bus.fifo_almostfull);
        found = 1'b0;
        win   = ptr;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
`ifdef FIFO_ARB_BURST_EN
        burst_go = (burst_cnt != '0) && (burst_cnt < BW'(BURST_LEN)) && bus.req[ptr];
        if (burst_go) begin
            found = 1'b1;
            win   = ptr;
        end
`endif
        xfer    = found && allow && !rst;
        bus.gnt = xfer ? (NUM_REQ'(1) << win) : '0;
    end

    // Register the granted word toward the FIFO and track pointer, count and overflow history
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fifo_wr_en   <= 1'b0;
            bus.fifo_data_in <= '0;
            bus.wr_count     <= '0;
            bus.err_overflow <= 1'b0;
            ptr              <= PW'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
            burst_cnt        <= '0;
`endif
        end else begin
            bus.fifo_wr_en <= xfer;
            if (xfer) begin
                bus.fifo_data_in <= bus.req_data[win*FIFO_WIDTH +: FIFO_WIDTH];
                bus.wr_count     <= bus.wr_count + 16'd1;
                ptr              <= win;
            end
            if (bus.fifo_overflow)
                bus.err_overflow <= 1'b1;
`ifdef FIFO_ARB_BURST_EN
            burst_cnt <= !xfer ? '0 : burst_go ? burst_cnt + 1'b1 : BW'(1);
`endif
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized and directed checks of fifo_wr_arbiter against a bench-side model and FIFO
module tb_fifo_wr_arbiter;
    localparam int W     = 16;
    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int BL    = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_wr_arbiter_if #(.FIFO_WIDTH(W), .NUM_REQ(N)) b();

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .NUM_REQ(N), .BURST_LEN(BL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(b.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic         c_rst;
    logic [N-1:0] c_req;
    logic [N*W-1:0] c_data;
    logic         c_rd;
    logic         c_ovf;

    logic [W-1:0] fq[$];

    bit           m_valid = 1'b0;
    bit           m_wr_en;
    bit           m_err;
    logic [W-1:0] m_data;
    logic [15:0]  m_count;
    int           m_ptr;
    int           m_burst;

    logic [N-1:0] last_gnt;
    logic         last_wr_en;
    logic [W-1:0] last_data;
    logic [15:0]  last_count;
    logic         last_err;
    logic         last_full;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: apply stimulus, check DUT against the model, then advance model and FIFO
    task automatic cycle();
        int  w;
        bit  allow;
        @(negedge clk);
        rst               = c_rst;
        b.req             = c_req;
        b.req_data        = c_data;
        b.fifo_overflow   = c_ovf;
        b.fifo_full       = (fq.size() >= DEPTH);
        b.fifo_almostfull = (fq.size() == DEPTH - 1);
        #1;
        allow = !b.fifo_full && !(m_valid && m_wr_en && b.fifo_almostfull);
        w = -1;
        if (!c_rst && allow) begin
            if (BURST && m_burst > 0 && m_burst < BL && c_req[m_ptr])
                w = m_ptr;
            else
                for (int k = 1; k <= N; k++)
                    if (w < 0 && c_req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        chk("gnt", b.gnt, (w < 0) ? 0 : (1 << w));
        if (m_valid) begin
            chk("wr_en", b.fifo_wr_en, m_wr_en);
            if (m_wr_en) chk("data_in", b.fifo_data_in, m_data);
            chk("wr_count", b.wr_count, m_count);
            chk("err_overflow", b.err_overflow, m_err);
        end
        last_gnt   = b.gnt;
        last_wr_en = b.fifo_wr_en;
        last_data  = b.fifo_data_in;
        last_count = b.wr_count;
        last_err   = b.err_overflow;
        last_full  = b.fifo_full;
        if (c_rd && fq.size() > 0) void'(fq.pop_front());
        if (m_valid && b.fifo_wr_en === 1'b1) begin
            chk("fifo_room", fq.size() < DEPTH, 1);
            fq.push_back(b.fifo_data_in);
        end
        if (c_rst) begin
            m_valid = 1'b1;
            m_wr_en = 1'b0;
            m_data  = '0;
            m_count = '0;
            m_err   = 1'b0;
            m_ptr   = N - 1;
            m_burst = 0;
        end else begin
            m_wr_en = (w >= 0);
            if (w >= 0) begin
                m_data  = c_data[w*W +: W];
                m_count = m_count + 16'd1;
                m_burst = (w == m_ptr && m_burst > 0 && m_burst < BL) ? m_burst + 1 : 1;
                m_ptr   = w;
            end else begin
                m_burst = 0;
            end
            if (c_ovf) m_err = 1'b1;
        end
    endtask

    task automatic do_reset();
        c_rst = 1'b1;
        cycle();
        c_rst = 1'b0;
        fq.delete();
    endtask

    initial begin
        logic [N-1:0] g[10];
        logic [W-1:0] d[10];
        logic         e[10];
        logic [15:0]  cn[10];
        int           writes;
        int           rd_pct;

        c_rst = 1'b1; c_req = '1; c_data = '0; c_rd = 1'b1; c_ovf = 1'b0;

        // reset with all requesting, then round-robin order with a drained FIFO
        cycle();
        chk("t1_gnt_rst0", last_gnt, 0);
        cycle();
        chk("t1_gnt_rst1", last_gnt, 0);
        c_rst = 1'b0;
        for (int i = 0; i < N; i++) c_data[i*W +: W] = W'(16'h1000 + i);
        for (int k = 0; k < 6; k++) begin
            cycle();
            g[k] = last_gnt; d[k] = last_data; e[k] = last_wr_en; cn[k] = last_count;
        end
        chk("t1_wr_en", e[0], 0);
        chk("t1_count", cn[0], 0);
        chk("t1_err", last_err, 0);
        if (!BURST) begin
            chk("t2_g0", g[0], 4'b0001); chk("t2_g1", g[1], 4'b0010);
            chk("t2_g2", g[2], 4'b0100); chk("t2_g3", g[3], 4'b1000);
            chk("t2_g4", g[4], 4'b0001);
            chk("t2_d1", d[1], 16'h1000); chk("t2_d2", d[2], 16'h1001);
            chk("t2_d3", d[3], 16'h1002); chk("t2_d4", d[4], 16'h1003);
            chk("t2_d5", d[5], 16'h1000);
        end
        chk("t2_count5", cn[5], 5);

        // single requester gets consecutive grants
        do_reset();
        c_req = 4'b0100; c_data = '0; c_data[2*W +: W] = 16'hA5A5;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) c_req = '0;
            if (k == 4) c_req = '1;
            cycle();
            g[k] = last_gnt; d[k] = last_data; e[k] = last_wr_en;
        end
        for (int k = 0; k < 3; k++) chk("t3_gnt", g[k], 4'b0100);
        for (int k = 1; k < 4; k++) begin
            chk("t3_wr_en", e[k], 1);
            chk("t3_data", d[k], 16'hA5A5);
        end
        chk("t3_ptr_next", g[4], 4'b1000);

        // FIFO never read: throttle stops at exactly DEPTH writes
        do_reset();
        c_rd = 1'b0; c_req = 4'b0011; writes = 0;
        for (int k = 0; k < 14; k++) begin
            cycle();
            writes += int'(last_wr_en);
        end
        chk("t4_writes", writes, 8);
        chk("t4_gnt_full", last_gnt, 0);
        chk("t4_full", last_full, 1);
        chk("t4_err", last_err, 0);
        c_rd = 1'b1;

`ifdef FIFO_ARB_BURST_EN
        // burst grants alternate in runs of BURST_LEN
        do_reset();
        c_req = 4'b0011;
        for (int k = 0; k < 9; k++) begin
            cycle();
            g[k] = last_gnt;
        end
        for (int k = 0; k < 9; k++)
            chk("t5_burst", g[k], (k >= 4 && k < 8) ? 4'b0010 : 4'b0001);
`endif

        // reset right after a transfer drops the in-flight write and restores ptr
        do_reset();
        c_req = '1;
        cycle();
        chk("t6_first", last_gnt, 4'b0001);
        c_rst = 1'b1;
        cycle();
        chk("t6_gnt_rst", last_gnt, 0);
        c_rst = 1'b0; c_req = 4'b1010;
        cycle();
        chk("t6_wr_en", last_wr_en, 0);
        chk("t6_gnt", last_gnt, 4'b0010);

        // overflow report is sticky
        c_req = '0; c_ovf = 1'b1;
        cycle();
        c_ovf = 1'b0;
        cycle();
        cycle();
        chk("t7_err_sticky", last_err, 1);

        // randomized traffic against the model
        do_reset();
        rd_pct = 60;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) rd_pct = (n / 200) % 3 == 0 ? 20 : (n / 200) % 3 == 1 ? 60 : 100;
            for (int i = 0; i < N; i++) begin
                if (!(c_req[i] && !last_gnt[i] && $urandom_range(19, 0) != 0)) begin
                    c_req[i] = $urandom_range(9, 0) < 5;
                    c_data[i*W +: W] = W'($urandom);
                end
            end
            c_rd  = $urandom_range(99, 0) < rd_pct;
            c_ovf = $urandom_range(199, 0) == 0;
            c_rst = $urandom_range(299, 0) == 0;
            cycle();
            if (c_rst) fq.delete();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
